dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 tb/tb_dmem_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Single-outstanding data-memory responder with a programmable response
//   latency. A request is accepted in IDLE, optionally waits LATENCY cycles,
//   then performs the storage access on the edge entering RESP and holds the
//   response until the requester takes it.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid / req_ready  request handshake (ready only in IDLE)
//   mem_read, mem_write    operation select (exactly one must be set)
//   mem_width              000 b, 001 h, 010 w, 100 bu, 101 hu
//   addr, wdata            byte address, low-aligned store data
//   rsp_valid / rsp_ready  response handshake
//   rdata, rsp_err         extended load data (0 on store/error), error flag
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_width,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = 3'((LATENCY == 0) ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    req_t             req_q, req_in, acc;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             accept, enter_resp;
    logic             misaligned, out_of_range, bad_op;
    logic [IDX_W-1:0] idx;
    logic [31:0]      word, shifted, load_val, wword;
    logic [3:0]       wmask;

    logic [31:0] mem_q [DEPTH_WORDS];

    assign req_in = '{rd: mem_read, wr: mem_write, width: mem_width,
                      addr: addr, wdata: wdata};
    assign accept = (state_q == IDLE) && req_valid;

    // With LATENCY=0 the access happens on the acceptance edge itself, before
    // req_q holds the request, so the live inputs are used while in IDLE.
    assign acc        = (state_q == IDLE) ? req_in : req_q;
    assign enter_resp = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == 3'd0));

    // ---------------- request checking and datapath ----------------
    // NOTE: every signal driven in always_comb gets a default first so that no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        misaligned   = ((acc.width[1:0] == 2'b01) && acc.addr[0]) ||
                       ((acc.width[1:0] == 2'b10) && (acc.addr[1:0] != 2'b00));
        out_of_range = {2'b00, acc.addr[31:2]} >= 32'(DEPTH_WORDS);
        bad_op       = (acc.rd == acc.wr) ||
                       (acc.width inside {3'b011, 3'b110, 3'b111}) ||
                       (acc.wr && acc.width[2]);
        err_d        = misaligned || out_of_range || bad_op;

        idx     = acc.addr[IDX_W+1:2];
        word    = mem_q[idx];
        shifted = word >> {acc.addr[1:0], 3'b000};

        // mem_width[2] selects zero extension; otherwise sign-extend.
        case (acc.width[1:0])
            2'b00:   load_val = {{24{~acc.width[2] & shifted[7]}},  shifted[7:0]};
            2'b01:   load_val = {{16{~acc.width[2] & shifted[15]}}, shifted[15:0]};
            default: load_val = word;
        endcase
        rdata_d = (!err_d && acc.rd) ? load_val : 32'd0;

        // Store data is replicated to every lane; the mask picks the lanes.
        case (acc.width[1:0])
            2'b00: begin
                wword = {4{acc.wdata[7:0]}};
                wmask = 4'b0001 << acc.addr[1:0];
            end
            2'b01: begin
                wword = {2{acc.wdata[15:0]}};
                wmask = acc.addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wword = acc.wdata;
                wmask = 4'b1111;
            end
        endcase
    end

    // ---------------- storage ----------------
    // NOTE: the storage array has no reset branch; its contents survive reset
    // and a reset edge only suppresses the write of an aborted request.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && !err_d && acc.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept)     req_q <= req_in;
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rdata     = rdata_q;
        rsp_err   = err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Two responders (LATENCY 1 and 3) driven by directed and random requests.
//   Expected responses come from a byte-array model and are queued at
//   acceptance; a negedge monitor pops and compares each response, its
//   latency and its stability while held.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH  = 64;
    localparam int PERIOD = 10;

    typedef struct {
        logic [31:0] data;
        bit          err;
        time         t_acc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        mem_read  [2];
    logic        mem_write [2];
    logic [2:0]  mem_width [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rdata     [2];
    logic        rsp_err   [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   have_cur [2];
    exp_t cur      [2];
    bit   bp_en    [2];
    logic [7:0] mem_m [2][DEPTH*4];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .mem_read(mem_read[g]), .mem_write(mem_write[g]),
            .mem_width(mem_width[g]), .addr(addr[g]), .wdata(wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rdata(rdata[g]), .rsp_err(rsp_err[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #(PERIOD/2) clk = ~clk;
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: little-endian byte array, rules applied directly.
    function automatic void model(input int d, input bit rd, input bit wr,
                                  input logic [2:0] w, input logic [31:0] a,
                                  input logic [31:0] wd,
                                  output logic [31:0] data, output bit err);
        int          size;
        logic [31:0] v;
        size = (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
        err  = (rd == wr) || (w == 3'b011) || (w == 3'b110) || (w == 3'b111) ||
               (wr && w[2]) || (size == 2 && a[0]) ||
               (size == 4 && a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
        data = 32'd0;
        if (err) return;
        if (wr) begin
            for (int i = 0; i < size; i++) mem_m[d][a+i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[d][a+i];
            if (!w[2] && v[8*size-1])
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            data = v;
        end
    endfunction

    function automatic void push_exp(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic bit pop_exp(input int d, output exp_t e);
        e = '{data: 32'd0, err: 1'b0, t_acc: 0};
        if (qsize(d) == 0) return 1'b0;
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        return 1'b1;
    endfunction

    // ---------------- monitor ----------------
    task automatic mon_step(input int d);
        exp_t e;
        int   lat;
        if (!rst_n) begin
            have_cur[d] = 1'b0;
            return;
        end
        if (!rsp_valid[d]) return;
        if (!have_cur[d]) begin
            if (!pop_exp(d, e)) begin
                check(1'b0, $sformatf("u%0d unexpected_rsp", d), 32'd1, 32'd0);
                e = '{data: rdata[d], err: rsp_err[d], t_acc: $time};
            end else begin
                lat = int'(($time - e.t_acc) / PERIOD);
                check(rdata[d] === e.data, $sformatf("u%0d rdata", d), rdata[d], e.data);
                check(rsp_err[d] === e.err, $sformatf("u%0d rsp_err", d),
                      32'(rsp_err[d]), 32'(e.err));
                check(lat == lat_of(d) + 1, $sformatf("u%0d latency", d),
                      32'(lat), 32'(lat_of(d) + 1));
            end
            cur[d]      = e;
            have_cur[d] = 1'b1;
        end else begin
            check(rdata[d] === cur[d].data, $sformatf("u%0d rdata_stable", d),
                  rdata[d], cur[d].data);
            check(rsp_err[d] === cur[d].err, $sformatf("u%0d err_stable", d),
                  32'(rsp_err[d]), 32'(cur[d].err));
            check(req_ready[d] === 1'b0, $sformatf("u%0d req_ready_busy", d),
                  32'(req_ready[d]), 32'd0);
        end
        if (rsp_ready[d]) have_cur[d] = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon_step(d);
    end

    // Random response backpressure.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (bp_en[d]) rsp_ready[d] = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input int d, input bit rd, input bit wr,
                         input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] wd);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        req_valid[d] = 1'b1;
        mem_read[d]  = rd;
        mem_write[d] = wr;
        mem_width[d] = w;
        addr[d]      = a;
        wdata[d]     = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            check(1'b0, $sformatf("u%0d accept_timeout", d), 32'd0, 32'd1);
        end else begin
            model(d, rd, wr, w, a, wd, e.data, e.err);
            e.t_acc = $time;
            push_exp(d, e);
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while ((qsize(d) != 0 || have_cur[d]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(qsize(d) == 0 && !have_cur[d], $sformatf("u%0d drain", d),
              32'(qsize(d)), 32'd0);
    endtask

    task automatic rand_ops(input int d, input int count);
        bit          rd, wr;
        logic [2:0]  w;
        logic [31:0] a, off;
        int          r;
        for (int i = 0; i < count; i++) begin
            r  = $urandom_range(0, 9);
            rd = (r < 4) || (r == 9);
            wr = (r >= 4 && r < 8) || (r == 9);
            if ($urandom_range(0, 3) != 0) begin
                r = $urandom_range(0, 4);
                w = (r < 3) ? 3'(r) : 3'(r + 1);
            end else begin
                w = 3'($urandom_range(0, 7));
            end
            off = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (w[1:0] == 2'b10)      off = 32'd0;
                else if (w[1:0] == 2'b01) off = off & 32'd2;
            end
            r = $urandom_range(0, 19);
            if (r == 0)      a = 32'hFFFF_FFF0 + off;
            else if (r < 3)  a = 32'($urandom_range(DEPTH, DEPTH + 3)) * 4 + off;
            else             a = 32'($urandom_range(0, DEPTH - 1)) * 4 + off;
            issue(d, rd, wr, w, a, $urandom);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; mem_read[d] = 1'b0; mem_write[d] = 1'b0;
            mem_width[d] = 3'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
            rsp_ready[d] = 1'b1; bp_en[d] = 1'b0; have_cur[d] = 1'b0;
            for (int i = 0; i < DEPTH*4; i++) mem_m[d][i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check(rsp_valid[d] === 1'b0, $sformatf("u%0d rst_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            check(req_ready[d] === 1'b1, $sformatf("u%0d rst_req_ready", d), 32'(req_ready[d]), 32'd1);
            check(rdata[d] === 32'd0, $sformatf("u%0d rst_rdata", d), rdata[d], 32'd0);
            check(rsp_err[d] === 1'b0, $sformatf("u%0d rst_err", d), 32'(rsp_err[d]), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Clear storage so model and DUT start identical.
        fork
            for (int i = 0; i < DEPTH; i++) issue(0, 1'b0, 1'b1, 3'b010, 32'(i*4), 32'd0);
            for (int i = 0; i < DEPTH; i++) issue(1, 1'b0, 1'b1, 3'b010, 32'(i*4), 32'd0);
        join
        drain(0); drain(1);

        // Word round trip, sign handling, partial store.
        issue(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        issue(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        issue(0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
        issue(0, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        issue(0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
        issue(0, 1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
        issue(0, 1'b0, 1'b1, 3'b000, 32'h11, 32'hAAAAAA55);
        issue(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        // Error cases, then confirm storage is untouched.
        issue(0, 1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
        issue(0, 1'b0, 1'b1, 3'b001, 32'h01, 32'hFFFF);
        issue(0, 1'b1, 1'b0, 3'b010, 32'(DEPTH*4), 32'h0);
        issue(0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0);
        issue(0, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        issue(0, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
        issue(0, 1'b0, 1'b1, 3'b100, 32'h10, 32'h0);
        issue(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        drain(0);

        // Backpressure: response held, new requests ignored.
        rsp_ready[0] = 1'b0;
        issue(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!rsp_valid[0] && n < 50) begin
                @(negedge clk);
                n++;
            end
            check(rsp_valid[0] === 1'b1, "u0 bp_rsp_seen", 32'(rsp_valid[0]), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req_valid[0] = 1'b1; mem_read[0] = 1'b0; mem_write[0] = 1'b1;
            mem_width[0] = 3'b010; addr[0] = 32'h10; wdata[0] = 32'hFFFFFFFF;
            @(negedge clk);
            check(req_ready[0] === 1'b0, "u0 bp_req_ready", 32'(req_ready[0]), 32'd0);
            check(rsp_valid[0] === 1'b1, "u0 bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        drain(0);
        issue(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        drain(0);

        // Reset while a store waits (LATENCY=3 instance).
        issue(1, 1'b0, 1'b1, 3'b010, 32'h30, 32'hDEADBEEF);
        issue(1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        drain(1);
        @(posedge clk); #1;
        req_valid[1] = 1'b1; mem_read[1] = 1'b0; mem_write[1] = 1'b1;
        mem_width[1] = 3'b010; addr[1] = 32'h20; wdata[1] = 32'h12345678;
        @(negedge clk);
        check(req_ready[1] === 1'b1, "u1 abort_accept", 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check(rsp_valid[1] === 1'b0, "u1 wait_no_rsp", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        check(rsp_valid[1] === 1'b0, "u1 abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check(req_ready[1] === 1'b1, "u1 abort_req_ready", 32'(req_ready[1]), 32'd1);
        check(rdata[1] === 32'd0, "u1 abort_rdata", rdata[1], 32'd0);
        check(rsp_err[1] === 1'b0, "u1 abort_err", 32'(rsp_err[1]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        issue(1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        drain(1);

        // Random traffic with random backpressure on both instances.
        bp_en[0] = 1'b1;
        bp_en[1] = 1'b1;
        fork
            rand_ops(0, 150);
            rand_ops(1, 150);
        join
        bp_en[0] = 1'b0;
        bp_en[1] = 1'b0;
        @(posedge clk); #2;
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        drain(0);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(PERIOD * 50000);
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "simulation did not complete");
    end

endmodule
